// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between a scan requester and mux_scan_ctrl.
// The auto_mode signal exists only when MUX_SCAN_AUTO_EN is defined.
interface mux_scan_ctrl_if;
   logic       start;
   logic       abort;
   logic       q_in;
   logic [1:0] sel;
   logic       busy;
   logic       done;
   logic [3:0] data_out;
`ifdef MUX_SCAN_AUTO_EN
   logic       auto_mode;
`endif

   modport master (
`ifdef MUX_SCAN_AUTO_EN
      output auto_mode,
`endif
      output start, abort, q_in,
      input  sel, busy, done, data_out
   );

   modport slave (
`ifdef MUX_SCAN_AUTO_EN
      input  auto_mode,
`endif
      input  start, abort, q_in,
      output sel, busy, done, data_out
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequences a 4:1 bit mux select through channels 0..3, dwelling DWELL cycles on each,
// and assembles the sampled bits into data_out. MUX_SCAN_AUTO_EN adds continuous rescans.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 2,
   parameter int unsigned CW    = 8
) (
   input logic             clk,
   input logic             rst_n,
   mux_scan_ctrl_if.slave  bus
);

   typedef enum logic [0:0] {StIdle, StScan} state_t;

   localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

   state_t        state_q;
   logic [1:0]    sel_q;
   logic          busy_q;
   logic          done_q;
   logic [3:0]    data_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    shadow_q;
   logic          stay;

`ifdef MUX_SCAN_AUTO_EN
   assign stay = bus.auto_mode;
`else
   assign stay = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sel_q    <= 2'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= 4'd0;
         cnt_q    <= '0;
         shadow_q <= 3'd0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start && !bus.abort) begin
                  state_q <= StScan;
                  sel_q   <= 2'd0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StScan: begin
               // Abort wins over a sample or completion landing on the same edge.
               if (bus.abort) begin
                  state_q  <= StIdle;
                  sel_q    <= 2'd0;
                  busy_q   <= 1'b0;
                  cnt_q    <= '0;
                  shadow_q <= 3'd0;
               end else if (cnt_q == LastCnt) begin
                  cnt_q <= '0;
                  if (sel_q != 2'd3) begin
                     shadow_q[sel_q] <= bus.q_in;
                     sel_q           <= sel_q + 2'd1;
                  end else begin
                     data_q <= {bus.q_in, shadow_q};
                     done_q <= 1'b1;
                     sel_q  <= 2'd0;
                     if (!stay) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.sel      = sel_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.data_out = data_q;

endmodule
